mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports. It takes the two source operands read on RD1/RD2 plus the destination register index, computes one of the eight M-extension operations over multiple cycles, and presents the 32-bit result with its destination index for writeback into WD3/A3. A start/busy/done handshake lets the control path stall issue while the unit iterates.

## Interface
Parameters:
- width, 32, operand and result width in bits
- address_lines, 5, width of the destination register index

Ports:
- clk  in  1  rising-edge clock
- areset  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- flush  in  1  synchronous abort; returns to IDLE, no done
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  width  operand A (from RD1)
- rs2  in  width  operand B (from RD2)
- rd_in  in  address_lines  destination index, captured with start
- busy  out  1  high in CALC
- done  out  1  one-cycle pulse, result valid
- result  out  width  held from done until next accepted start
- rd_out  out  address_lines  captured rd_in, held with result
- illegal  out  1  one-cycle pulse, op not supported in this build

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- IDLE/DONE & start: capture op, rs1, rs2, rd_in; take absolute values for signed operands, record result sign; go CALC (or DONE directly on fast path).
- start while busy ignored; op/rs1/rs2 need not be held after the accepting cycle.
- Multiply: radix-2 shift-add over width iterations into a 2*width product; sign-correct at the end (MULHSU: rs1 signed, rs2 unsigned). MUL returns low word, MULH* high word.
- Divide: restoring, one quotient bit per cycle over width iterations. Quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
- Fast path (no iteration, DONE next cycle): divide by zero → quotient all-ones, remainder = rs1; signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM) → quotient 0x80000000, remainder 0.
- DONE lasts exactly one cycle, then IDLE unless start accepted in that cycle.
- flush in any state: → IDLE next cycle, busy 0, no done, result/rd_out unchanged.

## Timing
- Reset values: busy 0, done 0, illegal 0, result 0, rd_out 0, state IDLE.
- Start accepted at cycle 0 → busy cycles 1..width → done at cycle width+1 (33 for width=32).
- Fast path: done at cycle 1, busy never asserted.
- Back-to-back: start in DONE cycle → busy in next cycle; throughput one op per width+1 cycles.
- areset mid-CALC: immediate return to reset values; operation discarded.
- flush and start same cycle: flush wins, start dropped.

## Configuration
- RV32M_DIV_EN defined: all eight ops implemented as above; illegal tied 0.
- Not defined: divider datapath and fast path compiled out; op[2]=1 at start → illegal and done pulse at cycle 1, result 0, rd_out captured; multiply ops unaffected.

## Structure
- Package mdu_pkg: op encoding localparams (MUL…REMU), state enum (IDLE, CALC, DONE), iteration counter width constant ($clog2(width)+1).
- One sub-module natural: mdu_divider (restoring divide step and fast-path detection), instantiated only under RV32M_DIV_EN; multiply loop and control FSM stay in mul_div_unit.

## Test plan
- MUL 7 × −3 (rs1=7, rs2=0xFFFFFFFD), rd_in=5 → done at cycle 33, result 0xFFFFFFEB, rd_out 5, busy high cycles 1..32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → done at cycle 1, result 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1.
- start MUL, flush at cycle 10 → busy 0 at cycle 11, no done; areset low at cycle 20 of another op → all outputs 0 immediately.
- Build without RV32M_DIV_EN: DIV → illegal and done at cycle 1, result 0; MUL 6×7 still → 42 at cycle 33.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and counter sizing for mul_div_unit.
package mdu_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic int cnt_bits(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int cnt_w = cnt_bits(32);

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: one restoring divide step on {rem, quotient} plus divide-by-zero
// and signed-overflow fast-path detection on the raw operands.
module mdu_divider #(
   parameter int width = 32
) (
   input  logic [2:0]       op,
   input  logic [width-1:0] rs1,
   input  logic [width-1:0] rs2,
   input  logic [width-1:0] hi,
   input  logic [width-1:0] lo,
   input  logic [width-1:0] divisor,
   output logic [width-1:0] hi_nx,
   output logic [width-1:0] lo_nx,
   output logic             fast,
   output logic [width-1:0] fast_res
);

   logic [width:0] tmp, diff;
   logic           zero, ovf;

   always_comb begin
      tmp      = {hi, lo[width-1]};
      diff     = tmp - {1'b0, divisor};
      hi_nx    = diff[width] ? tmp[width-1:0] : diff[width-1:0];
      lo_nx    = {lo[width-2:0], ~diff[width]};
      zero     = rs2 == '0;
      // only signed ops (op[0]=0) can overflow: most-negative / -1
      ovf      = !op[0] && rs1 == {1'b1, {(width-1){1'b0}}} && &rs2;
      fast     = op[2] && (zero || ovf);
      fast_res = op[1] ? (zero ? rs1 : '0) : (zero ? '1 : rs1);
   end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide with start/busy/done handshake.
// Define RV32M_DIV_EN to build the divider; otherwise divide ops raise illegal.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int width         = 32,
   parameter int address_lines = 5
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic                     start,
   input  logic                     flush,
   input  logic [2:0]               op,
   input  logic [width-1:0]         rs1,
   input  logic [width-1:0]         rs2,
   input  logic [address_lines-1:0] rd_in,
   output logic                     busy,
   output logic                     done,
   output logic [width-1:0]         result,
   output logic [address_lines-1:0] rd_out,
   output logic                     illegal
);

   localparam int cw = cnt_bits(width);

   state_t                   state, state_nx;
   logic [cw-1:0]            cnt;
   logic [width-1:0]         hi, lo, opb, abs_a, abs_b, m_hi, m_lo, hi_nx, lo_nx;
   logic [width-1:0]         q_fin, r_fin, fin, fast_res;
   logic [width:0]           msum;
   logic [2*width-1:0]       prod, sprod;
   logic [2:0]               op_r;
   logic [address_lines-1:0] rd_r;
   logic                     neg_q, neg_r, ill_r, sa, sb, accept, last, fast, ill, fast_go;

   always_comb begin
      accept  = start && !flush && state != CALC;
      sa      = rs1[width-1] && (op == MULH || op == MULHSU || op == DIV || op == REM);
      sb      = rs2[width-1] && (op == MULH || op == DIV || op == REM);
      abs_a   = sa ? -rs1 : rs1;
      abs_b   = sb ? -rs2 : rs2;
      last    = cnt == cw'(width - 1);
      fast_go = fast || ill;
      // shift-add: lo holds the remaining multiplier bits, hi the partial product
      msum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      m_hi    = msum[width:1];
      m_lo    = {msum[0], lo[width-1:1]};
   end

`ifdef RV32M_DIV_EN
   logic [width-1:0] d_hi, d_lo;

   mdu_divider #(.width(width)) u_div (
      .op       (op),
      .rs1      (rs1),
      .rs2      (rs2),
      .hi       (hi),
      .lo       (lo),
      .divisor  (opb),
      .hi_nx    (d_hi),
      .lo_nx    (d_lo),
      .fast     (fast),
      .fast_res (fast_res)
   );

   assign hi_nx = op_r[2] ? d_hi : m_hi;
   assign lo_nx = op_r[2] ? d_lo : m_lo;
   assign ill   = 1'b0;
`else
   assign hi_nx    = m_hi;
   assign lo_nx    = m_lo;
   assign fast     = 1'b0;
   assign fast_res = '0;
   assign ill      = op[2];
`endif

   always_comb begin
      prod  = {hi_nx, lo_nx};
      sprod = neg_q ? -prod : prod;
      q_fin = neg_q ? -lo_nx : lo_nx;
      r_fin = neg_r ? -hi_nx : hi_nx;
      fin   = op_r[2] ? (op_r[1] ? r_fin : q_fin)
                      : (op_r == MUL ? sprod[width-1:0] : sprod[2*width-1:width]);
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = flush               ? IDLE
               : accept              ? (fast_go ? DONE : CALC)
               : state == CALC       ? (last ? DONE : CALC)
               :                       IDLE;
   end

   always_comb begin
      busy    = state == CALC;
      done    = state == DONE;
      illegal = done && ill_r;
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         opb    <= '0;
         op_r   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         ill_r  <= 1'b0;
         rd_r   <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (accept) begin
         cnt   <= '0;
         hi    <= '0;
         lo    <= abs_a;
         opb   <= abs_b;
         op_r  <= op;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         ill_r <= ill;
         rd_r  <= rd_in;
         if (fast_go) begin
            result <= fast_res;
            rd_out <= rd_in;
         end
      end else if (state == CALC && !flush) begin
         cnt <= cnt + 1'b1;
         hi  <= hi_nx;
         lo  <= lo_nx;
         if (last) begin
            result <= fin;
            rd_out <= rd_r;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit timing, results and control paths.
// Divide vectors run when RV32M_DIV_EN is defined, illegal-op vectors otherwise.
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, done, illegal;
   logic [31:0] result;
   logic [4:0]  rd_out;
   int          errors = 0;
   int          checks = 0;

   mul_div_unit dut (
      .clk     (clk),
      .areset  (areset),
      .start   (start),
      .flush   (flush),
      .op      (op),
      .rs1     (rs1),
      .rs2     (rs2),
      .rd_in   (rd_in),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_out  (rd_out),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drives a request for one edge; returns in cycle 1 of the operation
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
      op = o; rs1 = a; rs2 = b; rd_in = r; start = 1'b1;
      tick();
      start = 1'b0; rs1 = '0; rs2 = '0; rd_in = '0;
   endtask

   task automatic wait_done(output int cyc, output int nbusy);
      cyc = 1;
      nbusy = 0;
      while (!done && cyc < 40) begin
         nbusy += int'(busy);
         tick();
         cyc++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, input logic [31:0] exp, input int exp_cyc, input logic exp_ill);
      int cyc, nb;
      issue(o, a, b, r);
      wait_done(cyc, nb);
      check({tag, " cycle"}, cyc, exp_cyc);
      check({tag, " busy"}, nb, exp_cyc - 1);
      check({tag, " result"}, result, exp);
      check({tag, " rd"}, rd_out, r);
      check({tag, " illegal"}, illegal, exp_ill);
      tick();
      check({tag, " pulse"}, {done, illegal}, 2'b00);
   endtask

   initial begin
      int cyc, nb;
      logic [31:0] held;
      tick();
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset illegal", illegal, 0);
      check("reset result", result, 0);
      check("reset rd", rd_out, 0);
      areset = 1'b1;
      tick();

      run("mul", MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 1'b0);
      run("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 33, 1'b0);
      run("mulh", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 33, 1'b0);
      run("mulhsu", MULHSU, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF, 33, 1'b0);
      run("mul6x7", MUL, 32'd6, 32'd7, 5'd31, 32'd42, 33, 1'b0);

`ifdef RV32M_DIV_EN
      run("div", DIV, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33, 1'b0);
      run("rem", REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33, 1'b0);
      run("divu", DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0);
      run("remu", REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1'b0);
      run("divu0", DIVU, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1, 1'b0);
      run("rem0", REM, 32'd5, 32'd0, 5'd10, 32'd5, 1, 1'b0);
      run("divovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 1'b0);
      run("removf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1, 1'b0);
`else
      run("div ill", DIV, 32'hFFFFFFF9, 32'd2, 5'd13, 32'h00000000, 1, 1'b1);
      run("remu ill", REMU, 32'd100, 32'd7, 5'd14, 32'h00000000, 1, 1'b1);
`endif

      // back-to-back: second start issued during the done cycle
      issue(MUL, 32'd3, 32'd5, 5'd15);
      wait_done(cyc, nb);
      check("b2b first", result, 32'd15);
      issue(MULHU, 32'h80000000, 32'd4, 5'd16);
      check("b2b busy", {busy, done}, 2'b10);
      wait_done(cyc, nb);
      check("b2b cycle", cyc, 33);
      check("b2b result", result, 32'd2);
      check("b2b rd", rd_out, 5'd16);
      tick();

      // flush mid-operation
      held = result;
      issue(MUL, 32'd9, 32'd9, 5'd20);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy", {busy, done}, 2'b00);
      wait_done(cyc, nb);
      check("flush no done", cyc, 40);
      check("flush result", result, held);
      check("flush rd", rd_out, 5'd16);

      // flush beats a simultaneous start
      flush = 1'b1;
      issue(MUL, 32'd2, 32'd2, 5'd21);
      flush = 1'b0;
      check("flush+start", {busy, done}, 2'b00);

      // asynchronous reset mid-operation
      issue(MUL, 32'd11, 32'd11, 5'd22);
      repeat (19) tick();
      check("pre-reset busy", busy, 1);
      #2 areset = 1'b0;
      #1;
      check("areset busy", busy, 0);
      check("areset done", done, 0);
      check("areset result", result, 0);
      check("areset rd", rd_out, 0);
      check("areset illegal", illegal, 0);
      tick();
      areset = 1'b1;
      tick();
      run("post-reset", MUL, 32'd12, 32'd12, 5'd23, 32'd144, 33, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
